nco_spi_interface: RTL and testbench



---
 rtl/nco_spi_interface_if.sv | 25 ++
 rtl/nco_spi_interface.sv | 95 +++++++++
 tb/tb_nco_spi_interface.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/nco_spi_interface_if.sv
// SPI pin and parallel-word bundle for nco_spi_interface.
//   i_SCLK, i_CS, i_MOSI : SPI pins driven by the host (master side)
//   o_MISO               : SPI readback data driven by the slave
//   r_parallel_output    : live receive shift register
//   r_parallel_output_latch : last complete word, consumed by the NCO core
interface nco_spi_interface_if #(
  parameter int unsigned WORD_WIDTH = 32
);
  logic                  i_SCLK;
  logic                  i_CS;
  logic                  i_MOSI;
  logic                  o_MISO;
  logic [WORD_WIDTH-1:0] r_parallel_output;
  logic [WORD_WIDTH-1:0] r_parallel_output_latch;

  modport master (
    output i_SCLK, i_CS, i_MOSI,
    input  o_MISO, r_parallel_output, r_parallel_output_latch
  );

  modport slave (
    input  i_SCLK, i_CS, i_MOSI,
    output o_MISO, r_parallel_output, r_parallel_output_latch
  );
endinterface

// File: rtl/nco_spi_interface.sv
// SPI mode-0 slave (MSB first) delivering NCO tuning words.
// SCLK/CS/MOSI are oversampled in the i_clock domain through 2-flop
// synchronizers; a third SCLK/CS stage provides edge detection.
// Ports:
//   i_clock : system clock, rising edge
//   i_reset : asynchronous, active-high reset
//   spi     : slave modport (pins in, MISO and parallel words out)
module nco_spi_interface #(
  parameter int unsigned WORD_WIDTH = 32
) (
  input logic               i_clock,
  input logic               i_reset,
  nco_spi_interface_if.slave spi
);
  localparam int unsigned CW = $clog2(WORD_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);

  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic mosi_s1, mosi_s2;

  logic [WORD_WIDTH-1:0] shift_q;
  logic [WORD_WIDTH-1:0] latch_q;
  logic [WORD_WIDTH-1:0] tx_q;
  logic [CW-1:0]         bit_cnt;
  // Set when a word completes inside a frame so the next SCLK fall reloads
  // tx with the freshly latched word instead of shifting.
  logic                  reload_pending;

  logic sclk_rise, sclk_fall, cs_fall;

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign cs_fall   = ~cs_s2 & cs_s3;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sclk_s1        <= 1'b0;
      sclk_s2        <= 1'b0;
      sclk_s3        <= 1'b0;
      cs_s1          <= 1'b1;
      cs_s2          <= 1'b1;
      cs_s3          <= 1'b1;
      mosi_s1        <= 1'b0;
      mosi_s2        <= 1'b0;
      shift_q        <= '0;
      latch_q        <= '0;
      tx_q           <= '0;
      bit_cnt        <= '0;
      reload_pending <= 1'b0;
    end else begin
      sclk_s1 <= spi.i_SCLK;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= spi.i_CS;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      mosi_s1 <= spi.i_MOSI;
      mosi_s2 <= mosi_s1;

      // CS high takes priority, so an SCLK rise coinciding with CS rise is dropped.
      if (cs_s2) begin
        bit_cnt        <= '0;
        reload_pending <= 1'b0;
      end else if (cs_fall) begin
        bit_cnt        <= '0;
        tx_q           <= latch_q;
        reload_pending <= 1'b0;
      end else begin
        if (sclk_rise) begin
          shift_q <= {shift_q[WORD_WIDTH-2:0], mosi_s2};
          if (bit_cnt == LAST_BIT) begin
            latch_q        <= {shift_q[WORD_WIDTH-2:0], mosi_s2};
            bit_cnt        <= '0;
            reload_pending <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        if (sclk_fall) begin
          if (reload_pending) begin
            tx_q           <= latch_q;
            reload_pending <= 1'b0;
          end else begin
            tx_q <= {tx_q[WORD_WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign spi.o_MISO                  = tx_q[WORD_WIDTH-1];
  assign spi.r_parallel_output       = shift_q;
  assign spi.r_parallel_output_latch = latch_q;
endmodule

// File: tb/tb_nco_spi_interface.sv
module tb_nco_spi_interface;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference model: the host's view of the link, in terms of words and bits.
  logic [31:0] m_shift;
  logic [31:0] m_latch;
  logic [31:0] m_tx_word;
  int          m_cnt;
  bit          in_frame;
  logic [31:0] miso_word;

  nco_spi_interface_if #(.WORD_WIDTH(32)) spi ();

  nco_spi_interface #(.WORD_WIDTH(32)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .spi     (spi.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_shift   = '0;
    m_latch   = '0;
    m_tx_word = '0;
    m_cnt     = 0;
  endtask

  task automatic cs_low();
    spi.i_CS = 1'b0;
    repeat (6) @(negedge clk);
    in_frame  = 1;
    m_cnt     = 0;
    m_tx_word = m_latch;
    miso_word = '0;
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi.i_CS = 1'b1;
    in_frame = 0;
    repeat (6) @(negedge clk);
  endtask

  // One SCLK period: MOSI set during the low phase, MISO sampled just before the rise.
  task automatic send_bit(input logic b);
    int unsigned extra;
    int unsigned hi;
    extra = $urandom_range(0, 2);
    hi    = $urandom_range(3, 6);
    repeat (3) @(negedge clk);
    spi.i_MOSI = b;
    repeat (3 + extra) @(negedge clk);
    if (in_frame) begin
      check("miso_bit", {31'b0, spi.o_MISO}, {31'b0, m_tx_word[31 - m_cnt]});
      miso_word = {miso_word[30:0], spi.o_MISO};
    end
    spi.i_SCLK = 1'b1;
    repeat (hi) @(negedge clk);
    spi.i_SCLK = 1'b0;
    if (in_frame) begin
      m_shift = (m_shift << 1) | {31'b0, b};
      m_cnt++;
      if (m_cnt == 32) begin
        m_latch   = m_shift;
        m_cnt     = 0;
        m_tx_word = m_latch;
      end
    end
    check("shift_live", spi.r_parallel_output, m_shift);
    check("latch_stable", spi.r_parallel_output_latch, m_latch);
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(w[31 - i]);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    in_frame   = 0;
    miso_word  = '0;
    model_reset();
    spi.i_SCLK = 1'b0;
    spi.i_CS   = 1'b1;
    spi.i_MOSI = 1'b0;
    rst        = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_shift", spi.r_parallel_output, 32'h0);
    check("rst_latch", spi.r_parallel_output_latch, 32'h0);
    check("rst_miso", {31'b0, spi.o_MISO}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // SCLK activity with CS high is ignored
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    check("idle_shift", spi.r_parallel_output, 32'h0);
    check("idle_latch", spi.r_parallel_output_latch, 32'h0);

    // Continuous frame
    cs_low();
    send_word(32'hFF000000, 8);
    check("after_bit8", spi.r_parallel_output, 32'h000000FF);
    send_word(32'h00000000, 8);
    check("after_bit16", spi.r_parallel_output, 32'h0000FF00);
    send_word(32'hFF550000, 16);
    check("word1_latch", spi.r_parallel_output_latch, 32'hFF00FF55);

    // Back-to-back word in the same frame; MISO carries the first word back
    send_word(32'hA5A5A5A5, 31);
    check("b2b_hold", spi.r_parallel_output_latch, 32'hFF00FF55);
    send_bit(1'b1);
    check("b2b_latch", spi.r_parallel_output_latch, 32'hA5A5A5A5);
    check("b2b_miso_word", miso_word, 32'hFF00FF55);
    cs_high();

    // Partial-word abort then realigned frame
    cs_low();
    send_word($urandom, 12);
    cs_high();
    check("partial_latch", spi.r_parallel_output_latch, 32'hA5A5A5A5);
    cs_low();
    send_word(32'h12345678, 32);
    check("realign_latch", spi.r_parallel_output_latch, 32'h12345678);
    cs_high();

    // MISO readback of a known latched word
    cs_low();
    send_word(32'hFF00FF55, 32);
    cs_high();
    cs_low();
    send_word($urandom, 32);
    check("readback_miso", miso_word, 32'hFF00FF55);
    cs_high();

    // Mid-frame asynchronous reset
    cs_low();
    send_word($urandom, 20);
    #3 rst = 1'b1;
    #1;
    check("async_rst_shift", spi.r_parallel_output, 32'h0);
    check("async_rst_latch", spi.r_parallel_output_latch, 32'h0);
    check("async_rst_miso", {31'b0, spi.o_MISO}, 32'h0);
    model_reset();
    spi.i_CS = 1'b1;
    in_frame = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    cs_low();
    send_word(32'h00000001, 32);
    check("post_rst_latch", spi.r_parallel_output_latch, 32'h00000001);
    cs_high();

    // Randomized frames: full words, multi-word frames and aborted partials
    for (int n = 0; n < 16; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 2);
      cs_low();
      if (kind == 0) begin
        send_word($urandom, 32);
      end else if (kind == 1) begin
        send_word($urandom, 32);
        send_word($urandom, 32);
      end else begin
        send_word($urandom, int'($urandom_range(1, 31)));
      end
      cs_high();
      check("rand_latch", spi.r_parallel_output_latch, m_latch);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
